// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM encoding, counter width and alignment helpers for dmem_responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, RESP = 2'b10} state_t;
  localparam int CNT_W = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  function automatic logic misaligned(input logic [1:0] lo);
    return |(lo & ALIGN_MASK);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage, one synchronous write port, asynchronous read port(s); debug read with DMEM_DEBUG_PORT_EN
module dmem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = mem[dbg_addr];
`endif
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory target with LATENCY-cycle response and stall; DMEM_DEBUG_PORT_EN adds dbg_addr/dbg_data
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  stall
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
`endif
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] idx_l, rd_idx;
  logic [1:0] lo_l;
  logic wr_l, rd_mis, rd_wr, we, unused_addr;
  logic [DATA_WIDTH-1:0] wdata_l, arr_rdata;
  logic req;
  assign req = mem_read | mem_write;
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];
  // With LATENCY=1 the response loads straight from the live request, so view it while idle
  assign rd_idx = state == IDLE ? addr[ADDR_WIDTH+1:2] : idx_l;
  assign rd_mis = state == IDLE ? misaligned(addr[1:0]) : misaligned(lo_l);
  assign rd_wr  = state == IDLE ? mem_write : wr_l;
  assign we     = state == RESP && wr_l && !misaligned(lo_l);
  assign ready  = state == RESP;
  assign err    = ready && misaligned(lo_l);
  assign stall  = req && !ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: if (req) begin
        state_nxt = LATENCY == 1 ? RESP : WAIT;
        cnt_nxt = CNT_W'(LATENCY - 2);
      end
      WAIT: begin
        state_nxt = !req ? IDLE : cnt == '0 ? RESP : WAIT;
        cnt_nxt = cnt == '0 ? cnt : cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      idx_l <= '0;
      lo_l <= '0;
      wr_l <= 1'b0;
      wdata_l <= '0;
      rdata <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (state == IDLE && req) begin
        idx_l <= addr[ADDR_WIDTH+1:2];
        lo_l <= addr[1:0];
        wr_l <= mem_write;
        wdata_l <= wdata;
      end
      if (state_nxt == RESP) rdata <= rd_mis ? '0 : rd_wr ? rdata : arr_rdata;
    end
  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk(clk),
    .we(we),
    .waddr(idx_l),
    .wdata(wdata_l),
    .raddr(rd_idx),
    .rdata(arr_rdata)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`endif
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (LATENCY 2 and 1) under directed and random traffic against a transaction-level model
module tb_dmem_responder;
  localparam int DEPTH = 256;
  logic clk, rst;
  logic mem_read [2], mem_write [2], rdy [2], err [2], stall [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [7:0] dbg_addr [2];
  logic [31:0] dbg_data [2];
  int total, pass, cyc;
  bit chk_en;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(g == 0 ? 2 : 1)) u_dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .addr(addr[g]), .wdata(wdata[g]),
      .rdata(rdata[g]), .ready(rdy[g]), .err(err[g]), .stall(stall[g])
`ifdef DMEM_DEBUG_PORT_EN
      , .dbg_addr(dbg_addr[g]), .dbg_data(dbg_data[g])
`endif
    );
  end
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL u%0d %s: got %h want %h (cycle %0d)", i, nm, act, exp, cyc);
  endtask
  function automatic int lat(input int i);
    return i == 0 ? 2 : 1;
  endfunction
  // Model: a transaction is accepted when idle, responds LATENCY-1 edges later, commits at the end of its response
  bit m_busy [2], m_resp [2], m_wr [2], m_rk [2];
  int m_age [2];
  logic [31:0] m_a [2], m_d [2], m_rd [2];
  logic [31:0] m_mem [2][DEPTH];
  bit m_k [2][DEPTH];
  function automatic bit mis(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction
  task automatic respond(input int i);
    m_busy[i] = 0;
    m_resp[i] = 1;
    if (mis(m_a[i])) begin
      m_rd[i] = 0;
      m_rk[i] = 1;
    end else if (!m_wr[i]) begin
      m_rd[i] = m_mem[i][m_a[i][9:2]];
      m_rk[i] = m_k[i][m_a[i][9:2]];
    end
  endtask
  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 0;
        m_resp[i] = 0;
        m_rd[i] = 0;
        m_rk[i] = 1;
      end else if (m_resp[i]) begin
        if (m_wr[i] && !mis(m_a[i])) begin
          m_mem[i][m_a[i][9:2]] = m_d[i];
          m_k[i][m_a[i][9:2]] = 1;
        end
        m_resp[i] = 0;
      end else if (m_busy[i]) begin
        if (!(mem_read[i] || mem_write[i])) m_busy[i] = 0;
        else begin
          m_age[i]++;
          if (m_age[i] == lat(i) - 1) respond(i);
        end
      end else if (mem_read[i] || mem_write[i]) begin
        m_a[i] = addr[i];
        m_d[i] = wdata[i];
        m_wr[i] = mem_write[i];
        m_age[i] = 0;
        if (lat(i) == 1) respond(i);
        else m_busy[i] = 1;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #4;
    if (chk_en)
      for (int i = 0; i < 2; i++) begin
        chk("ready", i, 32'(rdy[i]), 32'(m_resp[i]));
        chk("err", i, 32'(err[i]), 32'(m_resp[i] && mis(m_a[i])));
        chk("stall", i, 32'(stall[i]), 32'((mem_read[i] || mem_write[i]) && !m_resp[i]));
        if (m_rk[i]) chk("rdata", i, rdata[i], m_rd[i]);
`ifdef DMEM_DEBUG_PORT_EN
        if (m_k[i][dbg_addr[i]]) chk("dbg_data", i, dbg_data[i], m_mem[i][dbg_addr[i]]);
`endif
      end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    mem_read[i] = r;
    mem_write[i] = w;
    addr[i] = a;
    wdata[i] = d;
  endtask
  task automatic idle(input int i);
    mem_read[i] = 0;
    mem_write[i] = 0;
  endtask
  task automatic wait_ready(input int i, output logic [31:0] rd, output logic e, output int n);
    bit got = 0;
    n = 0;
    rd = 0;
    e = 0;
    for (int k = 0; k < 20; k++) begin
      #3;
      if (stall[i]) n++;
      if (rdy[i]) begin
        rd = rdata[i];
        e = err[i];
        got = 1;
        break;
      end
      step();
    end
    chk("ready_seen", i, 32'(got), 32'd1);
  endtask
  task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int n);
    drive(i, !w, w, a, d);
    wait_ready(i, rd, e, n);
    step();
    idle(i);
  endtask
  function automatic logic [31:0] rand_addr();
    logic [31:0] a = $urandom & 32'hF000_003C;
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction
  initial begin
    logic [31:0] rd;
    logic e;
    int n, c1, c2;
    bit seen;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      drive(i, 0, 0, 0, 0);
      dbg_addr[i] = 0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, 32'(rdy[i]), 32'd0);
      chk("rst_err", i, 32'(err[i]), 32'd0);
      chk("rst_rdata", i, rdata[i], 32'd0);
    end
    rst = 0;
    chk_en = 1;
    step();
    xact(0, 1, 32'h10, 32'hDEADBEEF, rd, e, n);
    chk("wr10_err", 0, 32'(e), 32'd0);
    chk("wr10_stall", 0, n, 2);
    xact(0, 0, 32'h10, 0, rd, e, n);
    chk("rd10_data", 0, rd, 32'hDEADBEEF);
    chk("rd10_err", 0, 32'(e), 32'd0);
    chk("rd10_stall", 0, n, 2);
    xact(0, 1, 32'h13, 32'h12345678, rd, e, n);
    chk("mis_err", 0, 32'(e), 32'd1);
    chk("mis_rdata", 0, rd, 32'd0);
    xact(0, 0, 32'h10, 0, rd, e, n);
    chk("mis_nowrite", 0, rd, 32'hDEADBEEF);
    xact(1, 1, 32'h0, 32'hA0A0_0001, rd, e, n);
    xact(1, 1, 32'h4, 32'hB0B0_0002, rd, e, n);
    drive(1, 1, 0, 32'h0, 0);
    wait_ready(1, rd, e, n);
    c1 = cyc;
    chk("b2b_rd0", 1, rd, 32'hA0A0_0001);
    chk("b2b_stall0", 1, n, 1);
    step();
    drive(1, 1, 0, 32'h4, 0);
    wait_ready(1, rd, e, n);
    c2 = cyc;
    chk("b2b_rd4", 1, rd, 32'hB0B0_0002);
    chk("b2b_stall4", 1, n, 1);
    chk("b2b_gap", 1, c2 - c1, 2);
    step();
    idle(1);
    xact(0, 1, 32'h20, 32'h1111_2222, rd, e, n);
    drive(0, 0, 1, 32'h20, 32'h9999_9999);
    step();
    mem_write[0] = 0;
    seen = 0;
    repeat (4) begin
      #3;
      seen |= rdy[0];
      step();
    end
    chk("abort_noready", 0, 32'(seen), 32'd0);
    xact(0, 0, 32'h20, 0, rd, e, n);
    chk("abort_nowrite", 0, rd, 32'h1111_2222);
    xact(0, 1, 32'h40, 32'h7777, rd, e, n);
    xact(0, 0, 32'h40, 0, rd, e, n);
    drive(0, 0, 1, 32'h40, 32'h5555);
    step();
    #1 rst = 1;
    idle(0);
    #1;
    chk("arst_ready", 0, 32'(rdy[0]), 32'd0);
    chk("arst_err", 0, 32'(err[0]), 32'd0);
    chk("arst_rdata", 0, rdata[0], 32'd0);
    step();
    rst = 0;
    step();
    xact(0, 0, 32'h40, 0, rd, e, n);
    chk("arst_nowrite", 0, rd, 32'h7777);
    chk("arst_idle_lat", 0, n, 2);
`ifdef DMEM_DEBUG_PORT_EN
    dbg_addr[0] = 8'd5;
    xact(0, 1, 32'h14, 32'hCAFEF00D, rd, e, n);
    #2;
    chk("dbg_commit", 0, dbg_data[0], 32'hCAFEF00D);
    chk("dbg_stall", 0, n, 2);
    step();
`endif
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        bit req = mem_read[i] || mem_write[i];
        int kind = $urandom_range(0, 2);
        if (req ? $urandom_range(0, 99) < 10 : $urandom_range(0, 99) < 50) begin
          if (req) idle(i);
          else drive(i, kind != 1, kind != 0, rand_addr(), $urandom);
        end else if (req && $urandom_range(0, 99) < 30) begin
          addr[i] = rand_addr();
          wdata[i] = $urandom;
        end
        dbg_addr[i] = 8'($urandom_range(0, 15));
      end
      step();
    end
    idle(0);
    idle(1);
    repeat (5) step();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
